// File: rtl/tiger_avalon_arbiter_if.sv
// rtl/tiger_avalon_arbiter_if.sv - Avalon-MM bus bundle shared by requester and fabric sides of the arbiter
//
// Signals:
//   address, writedata  32  command address and write data
//   byteenable          4   write byte enables
//   read, write         1   command strobes (never both high)
//   waitrequest         1   command not accepted this cycle
//   readdata            32  returned read data
//   readdatavalid       1   readdata is valid this cycle
// Modports:
//   master  drives the command, receives waitrequest and read returns
//   slave   receives the command, drives waitrequest and read returns
interface tiger_avalon_arbiter_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, writedata, byteenable, read, write,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/tiger_avalon_arbiter.sv
// rtl/tiger_avalon_arbiter.sv - two-port round-robin Avalon-MM arbiter with pipelined read routing
//
// Parameters:
//   MAX_PENDING  maximum reads in flight across both ports (power of two, 2..16)
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   p0     requester port 0 (processor data side), slave modport
//   p1     requester port 1 (accelerator/DMA side), slave modport
//   m      shared fabric master, master modport
module tiger_avalon_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    tiger_avalon_arbiter_if.slave  p0,
    tiger_avalon_arbiter_if.slave  p1,
    tiger_avalon_arbiter_if.master m
);
    localparam int AW = $clog2(MAX_PENDING);
    localparam int PW = AW + 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t state;
    lock_state_t state_next;
    logic        lock_id;
    logic        last;

    logic          tag_q [MAX_PENDING];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] pending;

    logic full;
    logic req0, req1;
    logic elig0, elig1;
    logic grant_valid;
    logic grant;
    logic sel_read, sel_write;
    logic cmd_present;
    logic accept;
    logic push, pop;
    logic stall;
    logic head;

    // Reads are blocked while the tag FIFO is full; writes never touch it.
    assign full  = (pending == PW'(MAX_PENDING));
    assign req0  = p0.read | p0.write;
    assign req1  = p1.read | p1.write;
    assign elig0 = p0.write | (p0.read & ~full);
    assign elig1 = p1.write | (p1.read & ~full);

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_OPEN;
            lock_id <= 1'b0;
        end else begin
            state <= state_next;
            if (stall) begin
                lock_id <= grant;
            end
        end
    end

    // Next lock state: a stalled command pins the grant; acceptance or a
    // dropped request releases it.
    always_comb begin
        state_next = ST_OPEN;
        if (stall) begin
            state_next = ST_LOCKED;
        end
    end

    // Grant selection
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state == ST_LOCKED) begin
            grant_valid = 1'b1;
            grant       = lock_id;
        end else if (elig0 && elig1) begin
            grant_valid = 1'b1;
            grant       = ~last;
        end else if (elig0) begin
            grant_valid = 1'b1;
            grant       = 1'b0;
        end else if (elig1) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    assign sel_read    = grant ? p1.read  : p0.read;
    assign sel_write   = grant ? p1.write : p0.write;
    assign cmd_present = grant_valid & (sel_read | sel_write);
    assign accept      = cmd_present & ~m.waitrequest;
    assign stall       = cmd_present & m.waitrequest;
    assign push        = accept & sel_read;
    // A readdatavalid with nothing outstanding (e.g. after reset) is dropped.
    assign pop         = m.readdatavalid & (pending != '0);
    assign head        = tag_q[rd_ptr];

    // Fabric command mux
    assign m.read       = grant_valid & sel_read;
    assign m.write      = grant_valid & sel_write;
    assign m.address    = !grant_valid ? 32'd0 : (grant ? p1.address    : p0.address);
    assign m.writedata  = !grant_valid ? 32'd0 : (grant ? p1.writedata  : p0.writedata);
    assign m.byteenable = !grant_valid ? 4'd0  : (grant ? p1.byteenable : p0.byteenable);

    assign p0.waitrequest = ~req0 | ~(grant_valid & ~grant) | m.waitrequest;
    assign p1.waitrequest = ~req1 | ~(grant_valid &  grant) | m.waitrequest;

    assign p0.readdata      = m.readdata;
    assign p1.readdata      = m.readdata;
    assign p0.readdatavalid = pop & ~head;
    assign p1.readdatavalid = pop &  head;

    // Round-robin history, FIFO pointers and outstanding-read count
    always_ff @(posedge clk) begin
        if (reset) begin
            last    <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (accept) begin
                last <= grant;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            pending <= pending + PW'(push) - PW'(pop);
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr] <= grant;
        end
    end
endmodule

// File: tb/tb_tiger_avalon_arbiter.sv
// tb/tb_tiger_avalon_arbiter.sv - directed self-checking bench for tiger_avalon_arbiter
module tb_tiger_avalon_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    tiger_avalon_arbiter_if p0_if ();
    tiger_avalon_arbiter_if p1_if ();
    tiger_avalon_arbiter_if m_if ();

    tiger_avalon_arbiter #(.MAX_PENDING(4)) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_if),
        .p1    (p1_if),
        .m     (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks happen 4ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_if.address = 32'd0; p0_if.writedata = 32'd0; p0_if.byteenable = 4'd0;
        p0_if.read = 1'b0; p0_if.write = 1'b0;
        p1_if.address = 32'd0; p1_if.writedata = 32'd0; p1_if.byteenable = 4'd0;
        p1_if.read = 1'b0; p1_if.write = 1'b0;
        m_if.waitrequest = 1'b0; m_if.readdata = 32'd0; m_if.readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        m_if.readdatavalid = 1'b1;
        #4;
        checks++;
        if ({m_if.read, m_if.write} !== 2'b00) begin
            errors++; $display("FAIL reset_cmd: got %b expected 00", {m_if.read, m_if.write});
        end
        checks++;
        if ({m_if.address, m_if.writedata, m_if.byteenable} !== 68'd0) begin
            errors++; $display("FAIL reset_bus: got addr %h wd %h be %h expected 0", m_if.address, m_if.writedata, m_if.byteenable);
        end
        checks++;
        if ({p0_if.waitrequest, p1_if.waitrequest} !== 2'b11) begin
            errors++; $display("FAIL reset_waitreq: got %b expected 11", {p0_if.waitrequest, p1_if.waitrequest});
        end
        checks++;
        if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin
            errors++; $display("FAIL reset_rdv: got %b expected 00", {p0_if.readdatavalid, p1_if.readdatavalid});
        end
        step();
        reset = 1'b0;
        m_if.readdatavalid = 1'b0;
    endtask

    task automatic test_single_read();
        p0_if.address = 32'h100; p0_if.byteenable = 4'hF; p0_if.read = 1'b1;
        #4;
        checks++;
        if ({m_if.read, m_if.address, p0_if.waitrequest} !== {1'b1, 32'h100, 1'b0}) begin
            errors++; $display("FAIL single_read_accept: got rd %b addr %h wr %b expected 1 00000100 0", m_if.read, m_if.address, p0_if.waitrequest);
        end
        step();
        p0_if.read = 1'b0;
        step();
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'hDEADBEEF;
        #4;
        checks++;
        if ({p0_if.readdatavalid, p0_if.readdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_read_p0_data: got v %b d %h expected 1 deadbeef", p0_if.readdatavalid, p0_if.readdata);
        end
        checks++;
        if (p1_if.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL single_read_p1_rdv: got %b expected 0", p1_if.readdatavalid);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        do_reset();
        p0_if.address = 32'h10; p0_if.writedata = 32'hA0A0_0000; p0_if.byteenable = 4'h3; p0_if.write = 1'b1;
        p1_if.address = 32'h20; p1_if.writedata = 32'hB1B1_1111; p1_if.byteenable = 4'hC; p1_if.write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 1) ? 32'h20 : 32'h10;
            exp_wd   = (i % 2 == 1) ? 32'hB1B1_1111 : 32'hA0A0_0000;
            #4;
            checks++;
            if ({m_if.write, m_if.address, m_if.writedata} !== {1'b1, exp_addr, exp_wd}) begin
                errors++; $display("FAIL b2b_cmd[%0d]: got w %b addr %h wd %h expected 1 %h %h", i, m_if.write, m_if.address, m_if.writedata, exp_addr, exp_wd);
            end
            checks++;
            if ({p0_if.waitrequest, p1_if.waitrequest} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_waitreq[%0d]: got %b expected %b", i, {p0_if.waitrequest, p1_if.waitrequest}, (i % 2 == 1) ? 2'b10 : 2'b01);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        // last = 1 after the back-to-back test, so port 0 would win a tie.
        p1_if.address = 32'h300; p1_if.byteenable = 4'hF; p1_if.read = 1'b1;
        m_if.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                p0_if.address = 32'h400; p0_if.writedata = 32'h55; p0_if.byteenable = 4'hF; p0_if.write = 1'b1;
            end
            #4;
            checks++;
            if ({m_if.read, m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest} !== {2'b10, 32'h300, 2'b11}) begin
                errors++; $display("FAIL stall_hold[%0d]: got r %b w %b addr %h wr %b%b expected 1 0 00000300 11", i, m_if.read, m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest);
            end
            step();
        end
        m_if.waitrequest = 1'b0;
        #4;
        checks++;
        if ({m_if.address, p1_if.waitrequest, p0_if.waitrequest} !== {32'h300, 2'b01}) begin
            errors++; $display("FAIL stall_release: got addr %h p1wr %b p0wr %b expected 00000300 0 1", m_if.address, p1_if.waitrequest, p0_if.waitrequest);
        end
        step();
        p1_if.address = 32'h304;
        #4;
        checks++;
        if ({m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest} !== {1'b1, 32'h400, 2'b01}) begin
            errors++; $display("FAIL stall_next_grant: got w %b addr %h wr %b%b expected 1 00000400 01", m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest);
        end
        step();
        idle_inputs();
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h1111;
        #4;
        checks++;
        if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b01) begin
            errors++; $display("FAIL stall_return: got %b expected 01", {p0_if.readdatavalid, p1_if.readdatavalid});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_full();
        logic [31:0] addrs [4];
        logic [4:0]  route;
        addrs[0] = 32'h200; addrs[1] = 32'h300; addrs[2] = 32'h204; addrs[3] = 32'h304;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                p0_if.address = addrs[i]; p0_if.read = 1'b1;
            end else begin
                p1_if.address = addrs[i]; p1_if.read = 1'b1;
            end
            #4;
            checks++;
            if ({m_if.read, m_if.address, (i % 2 == 1) ? p1_if.waitrequest : p0_if.waitrequest} !== {1'b1, addrs[i], 1'b0}) begin
                errors++; $display("FAIL full_issue[%0d]: got r %b addr %h wr %b expected 1 %h 0", i, m_if.read, m_if.address, (i % 2 == 1) ? p1_if.waitrequest : p0_if.waitrequest, addrs[i]);
            end
            step();
        end
        idle_inputs();
        p0_if.address = 32'h208; p0_if.read = 1'b1;
        p1_if.address = 32'h500; p1_if.writedata = 32'hCAFE; p1_if.byteenable = 4'hF; p1_if.write = 1'b1;
        #4;
        checks++;
        if ({m_if.read, m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest} !== {2'b01, 32'h500, 2'b10}) begin
            errors++; $display("FAIL full_write_pass: got r %b w %b addr %h wr %b%b expected 0 1 00000500 10", m_if.read, m_if.write, m_if.address, p0_if.waitrequest, p1_if.waitrequest);
        end
        step();
        p1_if.write = 1'b0;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'hA0;
        #4;
        checks++;
        if ({p0_if.waitrequest, m_if.read} !== 2'b10) begin
            errors++; $display("FAIL full_blocked: got p0wr %b mread %b expected 1 0", p0_if.waitrequest, m_if.read);
        end
        // Expected destination of each return, oldest first: 0,1,0,1 then the held read from port 0.
        route = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                m_if.readdata = 32'hA0 + 32'(i);
                #4;
            end
            checks++;
            if ({p0_if.readdatavalid, p1_if.readdatavalid} !== {~route[4 - i], route[4 - i]}) begin
                errors++; $display("FAIL full_route[%0d]: got %b expected %b", i, {p0_if.readdatavalid, p1_if.readdatavalid}, {~route[4 - i], route[4 - i]});
            end
            if (i == 1) begin
                checks++;
                if ({p0_if.waitrequest, m_if.read, m_if.address} !== {2'b01, 32'h208}) begin
                    errors++; $display("FAIL full_unblock: got p0wr %b mread %b addr %h expected 0 1 00000208", p0_if.waitrequest, m_if.read, m_if.address);
                end
            end
            step();
            if (i == 1) begin
                p0_if.read = 1'b0;
            end
        end
        idle_inputs();
        m_if.readdatavalid = 1'b1;
        #4;
        checks++;
        if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin
            errors++; $display("FAIL full_drained: got %b expected 00", {p0_if.readdatavalid, p1_if.readdatavalid});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        p0_if.address = 32'h600; p0_if.read = 1'b1;
        step();
        idle_inputs();
        p1_if.address = 32'h700; p1_if.read = 1'b1;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_if.readdatavalid = 1'b1; m_if.readdata = 32'hBAD0 + 32'(i);
            #4;
            checks++;
            if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin
                errors++; $display("FAIL stray_rdv[%0d]: got %b expected 00", i, {p0_if.readdatavalid, p1_if.readdatavalid});
            end
            step();
        end
        idle_inputs();
        p1_if.address = 32'h800; p1_if.read = 1'b1;
        #4;
        checks++;
        if ({m_if.read, m_if.address, p1_if.waitrequest} !== {1'b1, 32'h800, 1'b0}) begin
            errors++; $display("FAIL post_reset_read: got r %b addr %h wr %b expected 1 00000800 0", m_if.read, m_if.address, p1_if.waitrequest);
        end
        step();
        idle_inputs();
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h12345678;
        #4;
        checks++;
        if ({p0_if.readdatavalid, p1_if.readdatavalid, p1_if.readdata} !== {2'b01, 32'h12345678}) begin
            errors++; $display("FAIL post_reset_return: got %b %h expected 01 12345678", {p0_if.readdatavalid, p1_if.readdatavalid}, p1_if.readdata);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_full();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
